// File: rtl/jstk_pkg.sv
// Shared constants, state encoding and frame packing for the PmodJSTK SPI responder.
package jstk_pkg;

  localparam int JSTK_FRAME_BYTES = 5;
  localparam int JSTK_FRAME_BITS  = JSTK_FRAME_BYTES * 8;
  localparam int JSTK_CNT_W       = 6;
  localparam logic [5:0] JSTK_LED_CMD = 6'b100000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    HOLD
  } jstk_state_e;

  // Byte order on the wire: X low, X high, Y low, Y high, buttons.
  function automatic logic [JSTK_FRAME_BITS-1:0] jstk_pack(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [2:0] btn
  );
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for one asynchronous SPI line with registered
// rise/fall pulses; all stages clear to 0 so a low line never looks like a fall.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// PmodJSTK emulator: SPI mode-0 slave returning X/Y/buttons on MISO and
// decoding the master's LED command byte, oversampled in the clk domain.
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] LED_RESET   = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [2:0] btn_in,
  output logic [1:0] led,
  output logic [7:0] cmd_byte,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  jstk_state_e                state_q, state_d;
  logic [JSTK_CNT_W-1:0]      cnt_q, cnt_d;
  logic [JSTK_FRAME_BITS-1:0] tx_q, tx_d;
  logic [7:0]                 rx_q, rx_d;
  logic                       miso_q, miso_d;
  logic [1:0]                 led_q, led_d;
  logic [7:0]                 cmd_q, cmd_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       ovr_q, ovr_d;
  logic                       busy_q, busy_d;
  logic                       unused_sync;

  assign unused_sync = &{1'b0, sclk_lvl, mosi_rise, mosi_fall, tx_q[JSTK_FRAME_BITS-1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    miso_d  = miso_q;
    led_d   = led_q;
    cmd_d   = cmd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ovr_d   = ovr_q;
    busy_d  = ~cs_lvl;

    // A cs rise always takes priority over an sclk edge seen in the same cycle.
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        ovr_d  = 1'b0;
        if (cs_fall) begin
          state_d = SHIFT;
          tx_d    = jstk_pack(x_in, y_in, btn_in);
          miso_d  = tx_d[JSTK_FRAME_BITS-1];
          cnt_d   = '0;
          rx_d    = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b0 | 1'b1;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q < JSTK_CNT_W'(8)) begin
            rx_d = {rx_q[6:0], mosi_lvl};
          end
          // Results are published on the 40th rise so they land with frame_done.
          if (cnt_q == JSTK_CNT_W'(JSTK_FRAME_BITS - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            cmd_d   = rx_d;
            miso_d  = 1'b0;
            if (rx_d[7:2] == JSTK_LED_CMD) begin
              led_d = rx_d[1:0];
            end
          end
        end else if (sclk_fall) begin
          tx_d   = {tx_q[JSTK_FRAME_BITS-2:0], 1'b0};
          miso_d = tx_q[JSTK_FRAME_BITS-2];
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          if (sclk_rise) begin
            err_d = 1'b1;
            ovr_d = 1'b1;
          end
        end
      end
      HOLD: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sclk_rise && !ovr_q) begin
          err_d = 1'b1;
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      miso_q  <= 1'b0;
      led_q   <= LED_RESET;
      cmd_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      miso_q  <= miso_d;
      led_q   <= led_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign miso       = miso_q;
  assign led        = led_q;
  assign cmd_byte   = cmd_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed and randomized SPI-master frames against a byte-level model of the
// joystick responder: read-back bytes, LED/command decode, pulses and latencies.
module tb_jstk_spi_responder;

  localparam int         SYNC    = 2;
  localparam logic [1:0] LED_RST = 2'b01;
  localparam int         HALF    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       mosi;
  logic       cs;
  logic       miso;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic [2:0] btn_in;
  logic [1:0] led;
  logic [7:0] cmd_byte;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int err_cyc = 0;
  int last_rise_cyc = 0;
  int cs_rise_cyc = 0;
  logic miso_bits [64];
  logic [1:0] led_m;
  logic [7:0] cmd_m;

  jstk_spi_responder #(
    .SYNC_STAGES(SYNC),
    .LED_RESET(LED_RST)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso),
    .x_in(x_in), .y_in(y_in), .btn_in(btn_in), .led(led), .cmd_byte(cmd_byte),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Plays one master frame of nbits clocks; records the MISO bit seen at each rise.
  task automatic applyStimulus(input int nbits, input logic [7:0] cmd, input int change_bit,
                               input logic [9:0] new_x, input bit leave_low);
    @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 8) ? cmd[7-i] : 1'($urandom);
      wait_cycles(HALF);
      sclk = 1'b1;
      last_rise_cyc = cyc;
      miso_bits[i] = miso;
      if (i == 0) checkOutput("busy_in_frame", 64'(busy), 64'd1);
      wait_cycles(HALF);
      sclk = 1'b0;
      if (i == change_bit) x_in = new_x;
    end
    wait_cycles(HALF);
    if (!leave_low) begin
      cs = 1'b1;
      cs_rise_cyc = cyc;
      wait_cycles(20);
    end
  endtask

  // Runs a frame and checks it against the model built from the pre-frame inputs.
  task automatic doFrame(input string name, input int nbits, input logic [7:0] cmd,
                         input int change_bit, input logic [9:0] new_x);
    int xs, ys, bs, d0, e0, ones;
    int eb [5];
    logic [7:0] g;
    xs = int'(x_in);
    ys = int'(y_in);
    bs = int'(btn_in);
    eb[0] = xs % 256;
    eb[1] = xs / 256;
    eb[2] = ys % 256;
    eb[3] = ys / 256;
    eb[4] = bs;
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(nbits, cmd, change_bit, new_x, 1'b0);
    for (int b = 0; b < 5; b++) begin
      if (nbits >= 8 * (b + 1)) begin
        for (int k = 0; k < 8; k++) g[7-k] = miso_bits[8*b+k];
        checkOutput($sformatf("%s_byte%0d", name, b), 64'(g), 64'(eb[b]));
      end
    end
    if (nbits > 40) begin
      ones = 0;
      for (int i = 40; i < nbits; i++) ones += int'(miso_bits[i]);
      checkOutput($sformatf("%s_overrun_miso", name), 64'(ones), 64'd0);
    end
    checkOutput($sformatf("%s_done_pulses", name), 64'(done_cnt - d0), (nbits >= 40) ? 64'd1 : 64'd0);
    checkOutput($sformatf("%s_err_pulses", name), 64'(err_cnt - e0), (nbits != 40) ? 64'd1 : 64'd0);
    if (nbits >= 40) begin
      cmd_m = cmd;
      if (int'(cmd) / 4 == 32) led_m = 2'(int'(cmd) % 4);
    end
    checkOutput($sformatf("%s_led", name), 64'(led), 64'(led_m));
    checkOutput($sformatf("%s_cmd", name), 64'(cmd_byte), 64'(cmd_m));
    checkOutput($sformatf("%s_idle_miso", name), 64'(miso), 64'd0);
  endtask

  initial begin
    int d0, e0, nb;
    logic [7:0] c;
    rst = 1'b0;
    cs = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    x_in = '0;
    y_in = '0;
    btn_in = '0;
    led_m = LED_RST;
    cmd_m = 8'h00;
    wait_cycles(5);
    checkOutput("reset_miso", 64'(miso), 64'd0);
    checkOutput("reset_led", 64'(led), 64'(LED_RST));
    checkOutput("reset_cmd", 64'(cmd_byte), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(frame_done), 64'd0);
    checkOutput("reset_err", 64'(frame_err), 64'd0);
    rst = 1'b1;
    wait_cycles(10);

    x_in = 10'h2A5;
    y_in = 10'h13C;
    btn_in = 3'b101;
    doFrame("basic", 40, 8'h00, -1, 10'h0);
    checkOutput("done_latency", 64'(done_cyc - last_rise_cyc), 64'(SYNC + 2));

    doFrame("led_cmd", 40, 8'h83, -1, 10'h0);
    doFrame("non_led_cmd", 40, 8'h00, -1, 10'h0);

    x_in = 10'h155;
    doFrame("snap_old", 40, 8'h81, 3, 10'h3FF);
    doFrame("snap_new", 40, 8'h10, -1, 10'h0);

    doFrame("short", 17, 8'h82, -1, 10'h0);
    checkOutput("err_latency", 64'(err_cyc - cs_rise_cyc), 64'(SYNC + 2));

    doFrame("overrun", 48, 8'h82, -1, 10'h0);

    x_in = 10'h3FF;
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(20, 8'h81, -1, 10'h0, 1'b1);
    rst = 1'b0;
    wait_cycles(4);
    led_m = LED_RST;
    cmd_m = 8'h00;
    checkOutput("rst_mid_led", 64'(led), 64'(LED_RST));
    checkOutput("rst_mid_cmd", 64'(cmd_byte), 64'd0);
    rst = 1'b1;
    wait_cycles(20);
    checkOutput("rst_mid_miso", 64'(miso), 64'd0);
    checkOutput("rst_mid_done", 64'(done_cnt - d0), 64'd0);
    checkOutput("rst_mid_err", 64'(err_cnt - e0), 64'd0);
    cs = 1'b1;
    wait_cycles(20);
    checkOutput("rst_cs_rise_err", 64'(err_cnt - e0), 64'd0);
    doFrame("after_rst", 40, 8'h80, -1, 10'h0);

    for (int f = 0; f < 6; f++) begin
      x_in = 10'($urandom);
      y_in = 10'($urandom);
      btn_in = 3'($urandom);
      c = ($urandom_range(0, 1) == 1) ? (8'h80 | 8'($urandom_range(0, 3))) : 8'($urandom);
      case ($urandom_range(0, 3))
        0: nb = 12;
        1: nb = 44;
        default: nb = 40;
      endcase
      doFrame($sformatf("rand%0d", f), nb, c, -1, 10'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
